// File: rtl/ftoi_pkg.sv
// rtl/ftoi_pkg.sv - shared types and float-format constants for the ftoi pipeline
package ftoi_pkg;

  typedef enum logic [1:0] {
    RTZ = 2'b00,
    RNE = 2'b01,
    RDN = 2'b10,
    RUP = 2'b11
  } rnd_mode_t;

  typedef enum logic [1:0] {
    ZERO = 2'b00,
    NORM = 2'b01,
    INF  = 2'b10,
    NAN  = 2'b11
  } fclass_t;

  typedef struct packed {
    logic invalid;
    logic inexact;
  } ftoi_flags_t;

  localparam int FP_BIAS   = 127;
  localparam int FP_MANT_W = 23;
  localparam int FP_EXP_W  = 8;

endpackage

// File: rtl/ftoi_pipe_if.sv
// rtl/ftoi_pipe_if.sv - request/response handshake bundle for ftoi_pipe
interface ftoi_pipe_if
  import ftoi_pkg::*;
#(
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) ();

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_x;
  logic [1:0]        in_rnd;
  logic              in_unsigned;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_y;
  ftoi_flags_t       out_flags;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_x, in_rnd, in_unsigned, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_flags, out_tag
  );

  modport slave (
    input  in_valid, in_x, in_rnd, in_unsigned, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_flags, out_tag
  );

endinterface

// File: rtl/ftoi_round.sv
// rtl/ftoi_round.sv - S2 datapath: round, negate, saturate; flags only with FTOI_FLAGS_EN
module ftoi_round
  import ftoi_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic [OUT_W-1:0] mag,
  input  logic             guard,
  input  logic             sticky,
  input  logic             sign,
  input  rnd_mode_t        rnd,
  input  logic             uns,
  input  fclass_t          cls,
  output logic [OUT_W-1:0] y
`ifdef FTOI_FLAGS_EN
  ,
  output ftoi_flags_t      flags
`endif
);

  localparam logic [OUT_W-1:0] SMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SMIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W:0]   HALF = {2'b01, {(OUT_W-1){1'b0}}};

  logic             lost;
  logic             inc;
  logic             ovf;
  logic [OUT_W:0]   mag_r;
  logic [OUT_W-1:0] mag_lo;
  logic [OUT_W-1:0] pos_sat;
  logic [OUT_W-1:0] neg_sat;

  assign lost    = guard | sticky;
  assign mag_r   = {1'b0, mag} + {{OUT_W{1'b0}}, inc};
  assign mag_lo  = mag_r[OUT_W-1:0];
  assign pos_sat = uns ? {OUT_W{1'b1}} : SMAX;
  assign neg_sat = uns ? {OUT_W{1'b0}} : SMIN;

  // Round-up decision on the magnitude, direction-aware for RDN/RUP
  always_comb begin
    inc = 1'b0;
    case (rnd)
      RTZ:     inc = 1'b0;
      RNE:     inc = guard & (sticky | mag[0]);
      RDN:     inc = sign & lost;
      RUP:     inc = ~sign & lost;
      default: inc = 1'b0;
    endcase
  end

  // Range check of the rounded magnitude; exact -2^(OUT_W-1) still fits signed
  always_comb begin
    ovf = 1'b0;
    if (uns) ovf = sign ? (mag_r != '0) : mag_r[OUT_W];
    else     ovf = sign ? (mag_r > HALF) : (mag_r >= HALF);
  end

  // Result select: NaN to positive max, inf/overflow clamp by sign, else signed magnitude
  always_comb begin
    y = pos_sat;
    case (cls)
      NAN:     y = pos_sat;
      INF:     y = sign ? neg_sat : pos_sat;
      default: begin
        if (ovf)       y = sign ? neg_sat : pos_sat;
        else if (sign) y = -mag_lo;
        else           y = mag_lo;
      end
    endcase
  end

`ifdef FTOI_FLAGS_EN
  logic inv;
  assign inv   = (cls == NAN) || (cls == INF) || ovf;
  assign flags = '{invalid: inv, inexact: lost & ~inv};
`endif

endmodule

// File: rtl/ftoi_pipe.sv
// rtl/ftoi_pipe.sv - 2-stage binary32 to integer converter; FTOI_FLAGS_EN enables flags
module ftoi_pipe
  import ftoi_pkg::*;
#(
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input logic        clk,
  input logic        rstn,
  ftoi_pipe_if.slave bus
);

  localparam int SH_W = $clog2(OUT_W + 1);
  localparam int V_W  = OUT_W + FP_MANT_W + 1;
  localparam logic [FP_EXP_W-1:0] EXP_HALF = FP_EXP_W'(FP_BIAS - 1);
  localparam logic [FP_EXP_W-1:0] EXP_BIG  = FP_EXP_W'(FP_BIAS + OUT_W);

  logic                 s1_valid, s2_valid, s1_can_load, s2_can_load;
  logic                 sign;
  logic [FP_EXP_W-1:0]  expf;
  logic [FP_MANT_W-1:0] mant;
  logic [SH_W-1:0]      sh;
  logic [V_W-1:0]       vs;
  fclass_t              cls_d;
  logic [OUT_W-1:0]     mag_d;
  logic                 guard_d, sticky_d;

  logic [OUT_W-1:0]     s1_mag;
  logic                 s1_guard, s1_sticky, s1_sign, s1_uns;
  rnd_mode_t            s1_rnd;
  fclass_t              s1_cls;
  logic [TAG_W-1:0]     s1_tag;
  logic [OUT_W-1:0]     s2_y, rnd_y;
  logic [TAG_W-1:0]     s2_tag;

  assign sign = bus.in_x[31];
  assign expf = bus.in_x[30:23];
  assign mant = bus.in_x[22:0];

  // Shift by e+1 so the binary point lands between vs[24] and vs[23] (guard)
  assign sh = SH_W'(expf - EXP_HALF);
  assign vs = V_W'({1'b1, mant}) << sh;

  assign s2_can_load  = ~s2_valid | bus.out_ready;
  assign s1_can_load  = ~s1_valid | s2_can_load;
  assign bus.in_ready = s1_can_load;

  // Classify and align; exponents at or past OUT_W overflow regardless of
  // rounding, so they reuse the inf path and never reach the shifter
  always_comb begin
    cls_d    = NORM;
    mag_d    = '0;
    guard_d  = 1'b0;
    sticky_d = 1'b0;
    if (expf == '0)                   cls_d = ZERO;
    else if (expf == '1)              cls_d = (mant == '0) ? INF : NAN;
    else if (expf >= EXP_BIG)         cls_d = INF;
    else if (expf < EXP_HALF)         sticky_d = 1'b1;
    else begin
      mag_d    = vs[V_W-1:FP_MANT_W+1];
      guard_d  = vs[FP_MANT_W];
      sticky_d = |vs[FP_MANT_W-1:0];
    end
  end

  // Stage 1 register: aligned operand plus per-transaction controls
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      s1_mag    <= '0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_sign   <= 1'b0;
      s1_uns    <= 1'b0;
      s1_rnd    <= RTZ;
      s1_cls    <= ZERO;
      s1_tag    <= '0;
    end else if (s1_can_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_mag    <= mag_d;
        s1_guard  <= guard_d;
        s1_sticky <= sticky_d;
        s1_sign   <= sign;
        s1_uns    <= bus.in_unsigned;
        s1_rnd    <= rnd_mode_t'(bus.in_rnd);
        s1_cls    <= cls_d;
        s1_tag    <= bus.in_tag;
      end
    end
  end

`ifdef FTOI_FLAGS_EN
  ftoi_flags_t rnd_flags, s2_flags;
`endif

  ftoi_round #(.OUT_W(OUT_W)) u_round (
    .mag    (s1_mag),
    .guard  (s1_guard),
    .sticky (s1_sticky),
    .sign   (s1_sign),
    .rnd    (s1_rnd),
    .uns    (s1_uns),
    .cls    (s1_cls),
    .y      (rnd_y)
`ifdef FTOI_FLAGS_EN
    ,
    .flags  (rnd_flags)
`endif
  );

  // Stage 2 register: final result, held while the consumer stalls
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
      s2_tag   <= '0;
    end else if (s2_can_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_y   <= rnd_y;
        s2_tag <= s1_tag;
      end
    end
  end

`ifdef FTOI_FLAGS_EN
  // Stage 2 flag register, loaded alongside the result
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                        s2_flags <= '0;
    else if (s2_can_load && s1_valid) s2_flags <= rnd_flags;
  end
  assign bus.out_flags = s2_flags;
`else
  assign bus.out_flags = '0;
`endif

  assign bus.out_valid = s2_valid;
  assign bus.out_y     = s2_y;
  assign bus.out_tag   = s2_tag;

endmodule

// File: tb/tb_ftoi_pipe.sv
// tb/tb_ftoi_pipe.sv - scoreboard bench for ftoi_pipe at OUT_W=32 and OUT_W=16
module tb_ftoi_pipe;

  typedef struct {
    logic [31:0] x;
    logic [63:0] y;
    logic [1:0]  f;
    logic [4:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ftoi_pipe_if #(.OUT_W(32), .TAG_W(5)) b32 ();
  ftoi_pipe_if #(.OUT_W(16), .TAG_W(5)) b16 ();

  ftoi_pipe #(.OUT_W(32), .TAG_W(5)) dut32 (.clk(clk), .rstn(rstn), .bus(b32.slave));
  ftoi_pipe #(.OUT_W(16), .TAG_W(5)) dut16 (.clk(clk), .rstn(rstn), .bus(b16.slave));

  assign b16.in_valid    = b32.in_valid;
  assign b16.in_x        = b32.in_x;
  assign b16.in_rnd      = b32.in_rnd;
  assign b16.in_unsigned = b32.in_unsigned;
  assign b16.in_tag      = b32.in_tag;
  assign b16.out_ready   = b32.out_ready;

  exp_t q32[$];
  exp_t q16[$];
  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  bit stress_en = 1'b0;
  bit hold_ready = 1'b1;
  logic [4:0] tg = 5'd1;

  function automatic logic [1:0] fexp(input logic [1:0] f);
`ifdef FTOI_FLAGS_EN
    return f;
`else
    return 2'b00;
`endif
  endfunction

  // Reference: exact real value, rounded with floor/ceil, then clamped to range
  function automatic logic [65:0] ref_model(input logic [31:0] x, input logic [1:0] rnd,
                                            input logic uns, input int w);
    int ex = int'(x[30:23]);
    real sgn = x[31] ? -1.0 : 1.0;
    real hi_max = uns ? (2.0 ** w - 1.0) : (2.0 ** (w - 1) - 1.0);
    real lo_min = uns ? 0.0 : -(2.0 ** (w - 1));
    real v, r, f, d;
    logic inv, inx;
    longint yi;
    logic [63:0] y;
    inv = 1'b0;
    inx = 1'b0;
    r = 0.0;
    if (ex == 255) begin
      inv = 1'b1;
      r = (x[22:0] != 0 || !x[31]) ? hi_max : lo_min;
    end else if (ex != 0) begin
      v = sgn * (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (ex - 127));
      case (rnd)
        2'd0: r = (v < 0.0) ? $ceil(v) : $floor(v);
        2'd1: begin
          f = $floor(v);
          d = v - f;
          if (d > 0.5) r = f + 1.0;
          else if (d < 0.5) r = f;
          else r = ($floor(f / 2.0) * 2.0 == f) ? f : f + 1.0;
        end
        2'd2: r = $floor(v);
        default: r = $ceil(v);
      endcase
      inx = (r != v);
      if (r > hi_max) begin r = hi_max; inv = 1'b1; end
      else if (r < lo_min) begin r = lo_min; inv = 1'b1; end
    end
    if (inv) inx = 1'b0;
    yi = longint'(r);
    y = 64'(yi) & ((64'd1 << w) - 64'd1);
    return {inv, inx, y};
  endfunction

  function automatic logic [31:0] rand_x();
    int k = $urandom_range(0, 15);
    logic [7:0] e;
    logic [22:0] m;
    m = 23'($urandom);
    if (k == 0) e = 8'd0;
    else if (k == 1) e = 8'hFF;
    else if (k < 5) e = 8'($urandom_range(1, 254));
    else e = 8'($urandom_range(110, 164));
    if ($urandom_range(0, 3) == 0) m = {m[22:20], 20'd0};
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  task automatic send(input logic [31:0] x, input logic [1:0] rnd, input logic uns,
                      input logic [4:0] tag, input bit dir, input logic [63:0] ey,
                      input logic [1:0] ef);
    int n;
    exp_t e;
    logic [65:0] m;
    @(posedge clk);
    #1;
    b32.in_valid = 1'b1;
    b32.in_x = x;
    b32.in_rnd = rnd;
    b32.in_unsigned = uns;
    b32.in_tag = tag;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b32.in_ready && n < 100);
    if (!b32.in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout x=%h got in_ready=0 want 1", x);
    end else begin
      acc_cnt++;
      m = ref_model(x, rnd, uns, 32);
      e.x = x;
      e.tag = tag;
      e.y = dir ? ey : m[63:0];
      e.f = dir ? ef : m[65:64];
      q32.push_back(e);
      m = ref_model(x, rnd, uns, 16);
      e.y = m[63:0];
      e.f = m[65:64];
      q16.push_back(e);
    end
  endtask

  task automatic dsend(input logic [31:0] x, input logic [1:0] rnd, input logic uns,
                       input logic [63:0] ey, input logic [1:0] ef);
    send(x, rnd, uns, tg, 1'b1, ey, ef);
    tg = tg + 5'd1;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    b32.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q16.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q32.size() != 0 || q16.size() != 0) begin
      failures++;
      $display("FAIL drain pending got q32=%0d q16=%0d want 0 0", q32.size(), q16.size());
    end
  endtask

  task automatic cmp(input string nm, input exp_t e, input logic [63:0] y,
                     input logic [1:0] f, input logic [4:0] t);
    checks++;
    if (y !== e.y || f !== fexp(e.f) || t !== e.tag) begin
      failures++;
      $display("FAIL %s x=%h got y=%h f=%b tag=%0d want y=%h f=%b tag=%0d",
               nm, e.x, y, f, t, e.y, fexp(e.f), e.tag);
    end
  endtask

  always @(posedge clk) begin
    #1;
    b32.out_ready = stress_en ? ($urandom_range(0, 3) != 0) : hold_ready;
  end

  logic stall32 = 1'b0;
  logic [31:0] hy32;
  logic [1:0] hf32;
  logic [4:0] ht32;
  always @(negedge clk) begin : mon32
    exp_t e;
    if (!rstn) stall32 = 1'b0;
    else begin
      if (stall32) begin
        checks++;
        if (!b32.out_valid || b32.out_y !== hy32 || b32.out_flags !== hf32 || b32.out_tag !== ht32) begin
          failures++;
          $display("FAIL hold32 got v=%b y=%h tag=%0d want v=1 y=%h tag=%0d",
                   b32.out_valid, b32.out_y, b32.out_tag, hy32, ht32);
        end
      end
      stall32 = 1'b0;
      if (b32.out_valid) begin
        if (!b32.out_ready) begin
          stall32 = 1'b1;
          hy32 = b32.out_y;
          hf32 = b32.out_flags;
          ht32 = b32.out_tag;
        end else if (q32.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected32 got y=%h tag=%0d want no output", b32.out_y, b32.out_tag);
        end else begin
          e = q32.pop_front();
          cmp("result32", e, {32'd0, b32.out_y}, b32.out_flags, b32.out_tag);
        end
      end
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (rstn && b16.out_valid && b16.out_ready) begin
      if (q16.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected16 got y=%h tag=%0d want no output", b16.out_y, b16.out_tag);
      end else begin
        e = q16.pop_front();
        cmp("result16", e, {48'd0, b16.out_y}, b16.out_flags, b16.out_tag);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    b32.in_valid = 1'b0;
    b32.in_x = '0;
    b32.in_rnd = '0;
    b32.in_unsigned = 1'b0;
    b32.in_tag = '0;
    b32.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (b32.out_valid !== 1'b0 || b32.out_y !== '0 || b32.out_flags !== 2'b00 || b32.out_tag !== '0 ||
        b16.out_valid !== 1'b0 || b16.out_y !== '0) begin
      failures++;
      $display("FAIL reset_state got v=%b y=%h f=%b tag=%0d want 0 0 0 0",
               b32.out_valid, b32.out_y, b32.out_flags, b32.out_tag);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (b32.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got %b want 1", b32.in_ready);
    end

    dsend(32'h3FC00000, 2'd0, 1'b0, 64'h1, 2'b01);
    dsend(32'h3FC00000, 2'd1, 1'b0, 64'h2, 2'b01);
    dsend(32'h3FC00000, 2'd2, 1'b0, 64'h1, 2'b01);
    dsend(32'h3FC00000, 2'd3, 1'b0, 64'h2, 2'b01);
    dsend(32'hC0200000, 2'd1, 1'b0, 64'hFFFFFFFE, 2'b01);
    dsend(32'hC0200000, 2'd2, 1'b0, 64'hFFFFFFFD, 2'b01);
    dsend(32'hC0200000, 2'd3, 1'b0, 64'hFFFFFFFE, 2'b01);
    dsend(32'hC0200000, 2'd0, 1'b0, 64'hFFFFFFFE, 2'b01);
    dsend(32'h4F000000, 2'd0, 1'b0, 64'h7FFFFFFF, 2'b10);
    dsend(32'hCF000000, 2'd0, 1'b0, 64'h80000000, 2'b00);
    dsend(32'h7FC00000, 2'd1, 1'b0, 64'h7FFFFFFF, 2'b10);
    dsend(32'hBF000000, 2'd0, 1'b1, 64'h0, 2'b01);
    dsend(32'hBF800000, 2'd0, 1'b1, 64'h0, 2'b10);
    dsend(32'h4F800000, 2'd0, 1'b1, 64'hFFFFFFFF, 2'b10);
    dsend(32'h00000001, 2'd0, 1'b1, 64'h0, 2'b00);
    dsend(32'h47000000, 2'd0, 1'b0, 64'h8000, 2'b00);
    idle();
    drain();

    @(negedge clk);
    hold_ready = 1'b0;
    @(negedge clk);
    base = acc_cnt;
    fork
      begin
        for (int i = 1; i <= 4; i++) send(32'h40400000 + 32'(i << 20), 2'd0, 1'b0, 5'(i), 1'b0, '0, '0);
        idle();
      end
      begin
        int n = 0;
        while (acc_cnt < base + 2 && n < 50) begin
          @(negedge clk);
          n++;
        end
        @(negedge clk);
        checks++;
        if (b32.in_ready !== 1'b0) begin
          failures++;
          $display("FAIL backpressure_in_ready got %b want 0", b32.in_ready);
        end
        repeat (2) @(negedge clk);
        hold_ready = 1'b1;
      end
    join
    drain();

    @(negedge clk);
    stress_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(rand_x(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), tg, 1'b0, '0, '0);
      tg = tg + 5'd1;
      if ($urandom_range(0, 5) == 0) idle();
    end
    idle();
    @(negedge clk);
    stress_en = 1'b0;
    drain();

    send(32'h3FC00000, 2'd1, 1'b0, 5'd7, 1'b0, '0, '0);
    send(32'hC0200000, 2'd2, 1'b0, 5'd8, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    b32.in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    checks++;
    if (b32.out_valid !== 1'b0 || b16.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_flush got v32=%b v16=%b want 0 0", b32.out_valid, b16.out_valid);
    end
    q32.delete();
    q16.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (b32.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_recover_in_ready got %b want 1", b32.in_ready);
    end
    repeat (6) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      send(rand_x(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), tg, 1'b0, '0, '0);
      tg = tg + 5'd1;
    end
    idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
